neuron_in_sequencer: RTL and testbench
======================================

Name: neuron_in_sequencer

Overview:
- Upstream feeder for the 14-tap output neuron (13 features plus a bias tap).
- Accepts 13 signed 17-bit feature words serially over a valid/ready stream.
- Holds a writable 14-entry weight bank.
- Issues one packed x/w frame to the neuron, waits a fixed pipeline latency, then captures the neuron's 17-bit activation and presents it as a one-cycle-valid result.

Parameters:
- WORD_W, 17, width of a feature, weight or activation word (signed, 12 fractional bits).
- N_IN, 13, feature words per frame.
- N_TAP, 14, neuron taps (N_IN + 1 bias tap).
- PIPE_LAT, 8, cycles from the x_out/w_out update edge to a valid neuron_y (multiplier + 4 adder levels + LUT).
- BIAS_ONE, 17'h01000, constant placed on the bias tap (+1.0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_data  in  17  feature word
- s_valid  in  1  feature word valid
- s_ready  out  1  sequencer accepts a feature word this cycle
- w_we  in  1  weight write strobe
- w_addr  in  4  weight index 0..13 (13 = bias weight)
- w_data  in  17  weight value
- x_out  out  238  packed features to neuron; tap k at [17k+16:17k]
- w_out  out  238  packed weights to neuron, same packing
- ce_out  out  1  adder-tree clock enable to neuron
- neuron_y  in  17  neuron activation output
- y_out  out  17  captured activation
- y_valid  out  1  one-cycle pulse, y_out valid
- busy  out  1  high in WAIT

Behaviour:
- Reset is synchronous and active-high. While rst is high, at each clk edge the outputs and state take these values:
  - x_out, w_out, y_out = 0.
  - y_valid = 0, busy = 0, ce_out = 0.
  - Weight bank = all 0.
  - state = COLLECT, word count = 0, latency count = 0.
  - s_ready = 0 while rst is high; it rises in the first cycle after rst deasserts.
- Reset mid-frame or mid-WAIT discards partial words and any pending result. No y_valid is produced for the aborted frame.
- A feature word is accepted on an edge where s_valid and s_ready are both high. Accepted word n (0-based) goes to collect slot n.
- COLLECT:
  - s_ready = 1, busy = 0, ce_out = 0.
  - Word count increments on each accept; s_valid gaps just stall.
  - On the edge that accepts word 12 (call it E0):
    - x_out <= {BIAS_ONE, word12..word0}.
    - w_out <= snapshot of the weight bank, including any write landing on the same edge.
    - State goes to WAIT, latency count = 1, word count = 0.
- WAIT:
  - s_ready = 0, busy = 1, ce_out = 1.
  - x_out and w_out are held stable.
  - Latency count increments each edge.
  - At edge E0+PIPE_LAT: y_out <= neuron_y, y_valid <= 1, state <= COLLECT.
  - y_valid is high for exactly the one cycle after that edge. y_out holds until the next capture.
- Back-to-back frames: the earliest next-frame accept is at edge E0+PIPE_LAT+1, so the minimum frame period is 13+PIPE_LAT cycles.
- Weight bank:
  - Written in any state (not during reset); w_addr >= 14 is ignored.
  - Writes during WAIT do not disturb w_out; they take effect at the next E0.
- s_data presented during WAIT or reset is not accepted. The upstream source must hold it until s_ready.
- No arithmetic is done here. Words are passed bit-exact; BIAS_ONE is constant.

Decomposition:
- Package neuron_pkg holds:
  - WORD_W, N_IN, N_TAP, BIAS_ONE, PIPE_LAT default.
  - A tap-index typedef (4 bits).
  - The state enum {COLLECT, WAIT}.
  - The slice-packing function tap(k).
- One sub-module, neuron_wbank: 14x17 register bank with a write port and a full-width parallel snapshot output. The FSM, collect registers and latency counter stay in the top level.

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> all outputs 0, s_ready 0 during reset, 1 on the first cycle after.
- Basic frame:
  - Stimulus: weights w[k]=17'h01000 for all k; features 1..13 streamed with s_valid continuously high.
  - x_out = {17'h01000, 13, 12, ..., 1} packed at E0; busy high for PIPE_LAT cycles.
  - y_out = the neuron_y value (stub driving 17'h0ABCD) sampled at E0+8; y_valid is a single pulse.
- Backpressure: random s_valid gaps -> same x_out packing; E0 is delayed by the gap count; no word lost or duplicated.
- Stall: s_valid held high during WAIT with a changing s_data -> nothing accepted. The next frame's slot 0 holds the word present at the first cycle s_ready returns.
- Weight write:
  - Write w_addr=3 value 17'h1FFFF during WAIT -> w_out unchanged until the next E0, then tap 3 = 17'h1FFFF.
  - Write to w_addr=14 -> ignored.
- Abort: assert rst at latency count 4 -> no y_valid; the next full frame behaves as in the basic-frame scenario.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and types for the output-neuron input sequencer.
// A frame is 13 signed Q4.12 feature words plus one constant bias tap (+1.0).
// Frames are packed LSB-first: tap k occupies bits [17k+16 : 17k].
package neuron_pkg;

  localparam int WORD_W           = 17;
  localparam int N_IN             = 13;
  localparam int N_TAP            = N_IN + 1;
  localparam int PIPE_LAT_DEFAULT = 8;
  localparam int FRAME_W          = N_TAP * WORD_W;

  // +1.0 in Q4.12, driven on the bias tap of every frame.
  localparam logic [WORD_W-1:0] BIAS_ONE = 17'h01000;

  // Tap / word index; wide enough for 0..15 so out-of-range writes can be seen.
  typedef logic [3:0] tap_idx_t;

  localparam tap_idx_t LAST_WORD = tap_idx_t'(N_IN - 1);
  localparam tap_idx_t LAST_TAP  = tap_idx_t'(N_TAP - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    WAIT    = 1'b1
  } state_t;

  // Bit position of the LSB of tap k inside a packed frame.
  function automatic int tap(input int k);
    return k * WORD_W;
  endfunction

endpackage

// File: rtl/neuron_wbank.sv
// 14 x 17-bit weight bank for the output neuron.
// One synchronous write port; the snapshot output shows the bank as it will
// look after the current edge, so a frame launched on the same edge as a
// weight write picks up the new value.
module neuron_wbank
  import neuron_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  tap_idx_t           i_addr,
  input  logic [WORD_W-1:0]  i_data,
  output logic [FRAME_W-1:0] o_snapshot
);

  logic [WORD_W-1:0] r_bank [N_TAP];
  logic              w_wr;

  // Addresses past the bias tap are silently dropped.
  assign w_wr = i_we && (i_addr <= LAST_TAP);

  // Bank storage: cleared by reset, otherwise updated by the write port.
  // NOTE: this small register file is reset because the weights feed w_out and
  // must read as zero after reset; pure data pipes gated by a valid count (such
  // as the collect slots in the top level) are left without reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAP; k++) begin
        r_bank[k] <= '0;
      end
    end else if (w_wr) begin
      r_bank[i_addr] <= i_data;
    end
  end

  // Write-forwarded parallel view of the whole bank.
  always_comb begin
    o_snapshot = '0;
    for (int k = 0; k < N_TAP; k++) begin
      if (w_wr && (i_addr == tap_idx_t'(k))) begin
        o_snapshot[tap(k) +: WORD_W] = i_data;
      end else begin
        o_snapshot[tap(k) +: WORD_W] = r_bank[k];
      end
    end
  end

endmodule

// File: rtl/neuron_in_sequencer.sv
// Upstream feeder for the 14-tap output neuron.
// Collects 13 feature words from a valid/ready stream, launches one packed
// x/w frame (features + bias tap, weight snapshot), then waits PIPE_LAT
// cycles for the neuron pipeline and captures its activation as a
// single-cycle-valid result.
module neuron_in_sequencer
  import neuron_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               w_we,
  input  logic [3:0]         w_addr,
  input  logic [WORD_W-1:0]  w_data,
  output logic [FRAME_W-1:0] x_out,
  output logic [FRAME_W-1:0] w_out,
  output logic               ce_out,
  input  logic [WORD_W-1:0]  neuron_y,
  output logic [WORD_W-1:0]  y_out,
  output logic               y_valid,
  output logic               busy
);

  localparam int               LAT_W    = $clog2(PIPE_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(PIPE_LAT);

  state_t             r_state;
  state_t             w_state_next;
  tap_idx_t           r_word_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [WORD_W-1:0]  r_slot [N_IN-1];
  logic [FRAME_W-1:0] r_x_out;
  logic [FRAME_W-1:0] r_w_out;
  logic [WORD_W-1:0]  r_y_out;
  logic               r_y_valid;

  logic               w_collect;
  logic               w_busy;
  logic               w_capture;
  logic               w_accept;
  logic               w_last;
  logic [FRAME_W-1:0] w_frame;
  logic [FRAME_W-1:0] w_snapshot;

  // Acceptance is derived from the state register directly so it does not
  // loop back through the next-state logic.
  assign w_accept = s_valid && !rst && (r_state == COLLECT);
  assign w_last   = w_accept && (r_word_cnt == LAST_WORD);

  neuron_wbank u_wbank (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_addr     (w_addr),
    .i_data     (w_data),
    .o_snapshot (w_snapshot)
  );

  // State register.
  // NOTE: all sequential state is written with <= so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state control outputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_collect    = 1'b0;
    w_busy       = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      COLLECT: begin
        w_collect = 1'b1;
        if (w_last) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_lat_cnt == LAT_DONE) begin
          w_capture    = 1'b1;
          w_state_next = COLLECT;
        end
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  // Ready is forced low while reset is held, independent of the state.
  assign s_ready = w_collect && !rst;
  assign busy    = w_busy;
  assign ce_out  = w_busy;

  // Frame assembly: words 0..11 from the slots, word 12 straight off the
  // stream on the launching edge, constant bias on the top tap.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < N_IN - 1; k++) begin
      w_frame[tap(k) +: WORD_W] = r_slot[k];
    end
    w_frame[tap(N_IN - 1) +: WORD_W]  = s_data;
    w_frame[tap(N_TAP - 1) +: WORD_W] = BIAS_ONE;
  end

  // Collect slots for words 0..11; the word count decides which are live.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last) begin
      r_slot[r_word_cnt] <= s_data;
    end
  end

  // Counters, launched frame and captured activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_lat_cnt  <= '0;
      r_x_out    <= '0;
      r_w_out    <= '0;
      r_y_out    <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_y_valid <= w_capture;

      if (w_last) begin
        r_word_cnt <= '0;
        r_lat_cnt  <= LAT_ONE;
        r_x_out    <= w_frame;
        r_w_out    <= w_snapshot;
      end else if (w_accept) begin
        r_word_cnt <= r_word_cnt + tap_idx_t'(1);
      end

      if (w_capture) begin
        r_lat_cnt <= '0;
        r_y_out   <= neuron_y;
      end else if (r_state == WAIT) begin
        r_lat_cnt <= r_lat_cnt + LAT_ONE;
      end
    end
  end

  assign x_out   = r_x_out;
  assign w_out   = r_w_out;
  assign y_out   = r_y_out;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_neuron_in_sequencer.sv
// Scoreboard bench for neuron_in_sequencer.
// The driver keeps a transaction-level model (accepted-word queue, weight
// array, "busy until edge N" timestamp) and pushes one expected result per
// launched frame; an independent monitor pops and compares on every y_valid.
// The neuron is a stub whose output changes every cycle, so the capture
// edge is pinned down exactly.
`timescale 1ns/1ps
module tb_neuron_in_sequencer;
  import neuron_pkg::*;

  localparam int PL = PIPE_LAT_DEFAULT;

  logic               clk = 1'b0;
  logic               rst;
  logic [WORD_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic               w_we;
  logic [3:0]         w_addr;
  logic [WORD_W-1:0]  w_data;
  logic [FRAME_W-1:0] x_out;
  logic [FRAME_W-1:0] w_out;
  logic               ce_out;
  logic [WORD_W-1:0]  neuron_y;
  logic [WORD_W-1:0]  y_out;
  logic               y_valid;
  logic               busy;

  neuron_in_sequencer #(.PIPE_LAT(PL)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .x_out    (x_out),
    .w_out    (w_out),
    .ce_out   (ce_out),
    .neuron_y (neuron_y),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FRAME_W-1:0] x;
    logic [FRAME_W-1:0] w;
    logic [WORD_W-1:0]  y;
    int                 vedge;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [WORD_W-1:0] m_words[$];
  logic [WORD_W-1:0] m_bank [N_TAP];
  logic [WORD_W-1:0] seq_w [N_IN];
  int                edge_no    = 0;
  int                wait_until = 0;
  int                m_frames   = 0;
  bit                m_ready    = 1'b0;
  bit                m_busy     = 1'b0;
  bit                mon_en     = 1'b0;
  int                n_cmp      = 0;
  int                n_bad      = 0;

  task automatic check(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, want %h", name, edge_no, act, exp);
    end
  endtask

  // Neuron stub output as a function of the edge that last updated it.
  function automatic logic [WORD_W-1:0] stub_y(input int n);
    logic [31:0] t;
    t = 32'(n) * 32'h9E3779B1;
    return t[23:7];
  endfunction

  // One clock edge, with the behavioural model advanced alongside the DUT.
  task automatic tick();
    bit                 acc;
    exp_t               ne;
    acc = s_valid && m_ready;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      m_words.delete();
      exp_q.delete();
      wait_until = 0;
      foreach (m_bank[k]) m_bank[k] = '0;
    end else begin
      if (w_we && (w_addr < 4'(N_TAP))) m_bank[w_addr] = w_data;
      if (acc) begin
        m_words.push_back(s_data);
        if (m_words.size() == N_IN) begin
          ne.x = '0;
          ne.w = '0;
          for (int k = 0; k < N_IN; k++) ne.x[k*WORD_W +: WORD_W] = m_words[k];
          ne.x[N_IN*WORD_W +: WORD_W] = 17'h01000;
          for (int k = 0; k < N_TAP; k++) ne.w[k*WORD_W +: WORD_W] = m_bank[k];
          ne.y     = stub_y(edge_no + PL - 1);
          ne.vedge = edge_no + PL;
          exp_q.push_back(ne);
          wait_until = edge_no + PL;
          m_frames++;
          m_words.delete();
        end
      end
    end
    #1;
    neuron_y = stub_y(edge_no);
    m_busy   = (edge_no < wait_until);
    m_ready  = !rst && !m_busy;
  endtask

  task automatic set_rst(input logic v);
    rst     = v;
    m_ready = !v && !m_busy;
    #1;
  endtask

  task automatic reset_for(input int n);
    set_rst(1'b1);
    check("s_ready_rst_asserted", s_ready, 1'b0);
    repeat (n) tick();
    check("x_out_reset", x_out, '0);
    check("w_out_reset", w_out, '0);
    check("y_out_reset", y_out, '0);
    check("y_valid_reset", y_valid, 1'b0);
    check("busy_reset", busy, 1'b0);
    check("ce_out_reset", ce_out, 1'b0);
    check("s_ready_reset", s_ready, 1'b0);
    set_rst(1'b0);
    check("s_ready_after_reset", s_ready, 1'b1);
  endtask

  task automatic write_w(input logic [3:0] a, input logic [WORD_W-1:0] d);
    w_we   = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_we   = 1'b0;
  endtask

  task automatic send_fixed();
    for (int i = 0; i < N_IN; i++) begin
      int g;
      g       = 0;
      s_valid = 1'b1;
      s_data  = seq_w[i];
      while (!m_ready && g < 4 * PL) begin
        tick();
        g++;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g       = 0;
    s_valid = 1'b0;
    while (exp_q.size() > 0 && g < 4 * PL) begin
      tick();
      g++;
    end
    check("results_outstanding", exp_q.size(), 0);
  endtask

  task automatic stream_random(input int nf, input int p_valid, input int p_we);
    int target;
    int g;
    target = m_frames + nf;
    g      = 0;
    while (m_frames < target && g < 400 * nf) begin
      s_valid = ($urandom_range(99) < p_valid);
      s_data  = WORD_W'($urandom);
      if ($urandom_range(99) < p_we) begin
        w_we   = 1'b1;
        w_addr = 4'($urandom_range(15));
        w_data = WORD_W'($urandom);
      end else begin
        w_we = 1'b0;
      end
      tick();
      g++;
    end
    s_valid = 1'b0;
    w_we    = 1'b0;
  endtask

  // Monitor: handshake/status every cycle, scoreboard pop on each result.
  always @(negedge clk) begin
    if (mon_en) begin
      check("s_ready", s_ready, m_ready);
      check("busy", busy, m_busy);
      check("ce_out", ce_out, m_busy);
      if (y_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_y_valid", y_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("y_valid_edge", edge_no, mon_e.vedge);
          check("x_out", x_out, mon_e.x);
          check("w_out", w_out, mon_e.w);
          check("y_out", y_out, mon_e.y);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N_IN; i++) seq_w[i] = WORD_W'(i + 1);
    s_valid  = 1'b0;
    s_data   = '0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    neuron_y = '0;
    rst      = 1'b1;

    repeat (2) tick();
    mon_en = 1'b1;
    set_rst(1'b0);

    // Partial frame, then a 3-cycle reset with s_valid still asserted.
    s_valid = 1'b1;
    repeat (5) begin
      s_data = WORD_W'($urandom);
      tick();
    end
    reset_for(3);
    s_valid = 1'b0;

    // Basic frame: unit weights, features 1..13 back to back.
    for (int k = 0; k < N_TAP; k++) write_w(4'(k), 17'h01000);
    send_fixed();
    drain();

    // Weight writes during WAIT stay invisible until the next launch.
    send_fixed();
    tick();
    write_w(4'd3, 17'h1FFFF);
    write_w(4'd14, 17'h15555);
    write_w(4'd15, 17'h0AAAA);
    drain();
    send_fixed();
    drain();

    // Backpressure with random gaps and random weight traffic.
    stream_random(6, 60, 15);
    drain();

    // s_valid held high with changing data through every WAIT.
    stream_random(4, 100, 0);
    drain();

    // Abort at latency count 4, then a clean frame.
    for (int k = 0; k < N_TAP; k++) write_w(4'(k), 17'h01000);
    send_fixed();
    repeat (3) tick();
    reset_for(2);
    repeat (PL + 2) tick();
    for (int k = 0; k < N_TAP; k++) write_w(4'(k), 17'h01000);
    send_fixed();
    drain();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
